// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the multi-cycle core. It owns the fetch PC and issues word
// reads to instruction memory over a req/ack handshake, which may take any
// number of cycles to complete. Returned words are stored with their PC in a
// small FIFO and handed to decode over a valid/ready interface. A redirect
// (branch/jump/call/ret) flushes the FIFO and any in-flight fetch.
//
// Parameters:
//   ADDR_W   - PC / word-address width (PC advances by 1 per instruction)
//   DATA_W   - instruction width
//   DEPTH    - FIFO entries, 2 or 4 (must be a power of two so pointers wrap)
//   RESET_PC - fetch PC after reset
//
// Ports:
//   clock, reset         - rising-edge clock, async active-high reset
//   imem_req, imem_addr  - registered read request and word address
//   imem_ack, imem_rdata - one-cycle completion pulse with read data
//   redirect_valid/_pc   - one-cycle redirect strobe and new fetch target
//   instr_valid          - FIFO non-empty
//   instr, instr_pc      - head entry (both 0 when FIFO empty)
//   instr_ready          - decode consumes the head this cycle
//
// Build option:
//   IFU_PERF_CNT_EN - adds saturating fetch_count (kept acks, 32 bit) and
//                     flush_count (redirects, 16 bit) output ports.
//
// State      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no request outstanding; FIFO full or just reset
// ST_WAIT    | request for imem_addr outstanding; its data will be kept
// ST_DRAIN   | squashed request outstanding; its data will be discarded
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [15:0]       flush_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];

    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_upd;
    logic              space_now;
    logic              space_after;
    logic [ADDR_W-1:0] fetch_pc_inc;

    assign pop          = instr_valid & instr_ready;
    // Only a kept ack pushes; a redirect in the same cycle discards the word.
    assign push         = (state == ST_WAIT) & imem_ack & ~redirect_valid;
    assign fetch_pc_inc = fetch_pc + 1'b1;

    always_comb begin
        count_upd = count;
        if (push && !pop) begin
            count_upd = count + 1'b1;
        end else if (!push && pop) begin
            count_upd = count - 1'b1;
        end
    end

    assign space_now   = (count < CNT_W'(DEPTH));
    // Checked after this cycle's push/pop so a zero-wait memory streams at
    // one instruction per cycle while decode keeps up.
    assign space_after = (count_upd < CNT_W'(DEPTH));

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? q_data[head] : '0;
    assign instr_pc    = instr_valid ? q_pc[head]   : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            fetch_pc  <= RST_PC;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            imem_req  <= 1'b0;
            imem_addr <= RST_PC;
        end else if (redirect_valid) begin
            // Flush wins over push and pop; a same-cycle pop is simply lost
            // with the rest of the queue (decode has already taken it).
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            fetch_pc <= redirect_pc;
            case (state)
                ST_IDLE: begin
                    state     <= ST_WAIT;
                    imem_req  <= 1'b1;
                    imem_addr <= redirect_pc;
                end
                ST_WAIT, ST_DRAIN: begin
                    if (imem_ack) begin
                        state     <= ST_WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= redirect_pc;
                    end else begin
                        // Old request still owns the bus; keep req/addr.
                        state <= ST_DRAIN;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end else begin
            count <= count_upd;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (space_now) begin
                        state     <= ST_WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end else begin
                        imem_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        fetch_pc <= fetch_pc_inc;
                        if (space_after) begin
                            imem_addr <= fetch_pc_inc;
                        end else begin
                            state    <= ST_IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Queue was flushed when we entered DRAIN, so no space
                    // check is needed before reissuing.
                    if (imem_ack) begin
                        state     <= ST_WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Payload storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clock) begin
        if (push) begin
            q_pc[tail]   <= fetch_pc;
            q_data[tail] <= imem_rdata;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (push && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 1'b1;
            end
            if (redirect_valid && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    instr_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (2),
        .RESET_PC (0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .flush_count    (flush_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] rpc;
        int          lat;
        logic [7:0]  rmask;
        int          n;
        logic [31:0] first_pc;
        logic [31:0] first_instr;
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   mem_lat = 1;
    int   mem_cnt = 0;
    bit   popped;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h0000_1000 + a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc0, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.pc   = pc0 + 32'(k);
            e.data = memf(e.pc);
            sb.push_back(e);
        end
    endtask

    // One cycle: memory model responds, inputs driven, head checked if popped.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        exp_t e;
        @(negedge clock);
        reset = 1'b0;
        if (imem_req) begin
            if (mem_cnt + 1 >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = memf(imem_addr);
                mem_cnt    = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                mem_cnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            mem_cnt    = 0;
        end
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        popped = instr_valid && rdy;
        if (popped) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pop: got pc %h, none expected", instr_pc);
            end else begin
                e = sb.pop_front();
                check("pop_pc", instr_pc, e.pc);
                check("pop_instr", instr, e.data);
            end
        end
    endtask

    task automatic run_pops(input int n, input logic [7:0] mask);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 300) begin
            step(mask[cyc % 8], 1'b0, 32'h0);
            if (popped) got++;
            cyc++;
        end
        check("pops_within_budget", 32'(got), 32'(n));
    endtask

    // Asserts reset mid-cycle, checks outputs at once; step() releases it.
    task automatic apply_reset();
        @(negedge clock);
        #2;
        reset          = 1'b1;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        mem_cnt        = 0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        sb.delete();
        @(posedge clock);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'h0000_0100, 1, 8'hFF, 5, 32'h0000_0100, 32'h0000_1100};
        vecs[1] = '{32'h0000_0200, 2, 8'hAA, 5, 32'h0000_0200, 32'h0000_1200};
        vecs[2] = '{32'h0000_0300, 4, 8'h0F, 4, 32'h0000_0300, 32'h0000_1300};
        vecs[3] = '{32'hFFFF_FFFE, 1, 8'hCC, 4, 32'hFFFF_FFFE, 32'h0000_0FFE};
        vecs[4] = '{32'h0000_0400, 3, 8'h01, 3, 32'h0000_0400, 32'h0000_1400};

        reset          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;

        // Zero-wait streaming, decode always ready.
        apply_reset();
        mem_lat = 1;
        push_exp(32'h0, 8);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 32'h0);
            check("stream_popped", 32'(popped), 1);
            check("stream_req_high", imem_req, 1);
        end
        check("stream_sb_empty", 32'(sb.size()), 0);

        // Reset while a request is outstanding.
        check("pre_reset_req", imem_req, 1);
        apply_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("first_req", imem_req, 1);
        check("first_req_addr", imem_addr, 0);

        // Backpressure: queue fills to DEPTH, then requests stop.
        repeat (10) step(1'b0, 1'b0, 32'h0);
        check("full_req_low", imem_req, 0);
        check("full_valid", instr_valid, 1);
        check("full_head_pc", instr_pc, 0);
        push_exp(32'h0, 4);
        run_pops(4, 8'hFF);

        // Redirect while a slow request to pc 5 is outstanding.
        apply_reset();
        mem_lat = 3;
        step(1'b0, 1'b1, 32'h5);
        step(1'b0, 1'b1, 32'h40);
        check("req_pc5_addr", imem_addr, 32'h5);
        step(1'b0, 1'b0, 32'h0);
        check("drain_hold_req", imem_req, 1);
        check("drain_hold_addr", imem_addr, 32'h5);
        begin
            bit found = 0;
            for (int c = 0; c < 8 && !found; c++) begin
                step(1'b0, 1'b0, 32'h0);
                if (imem_req && imem_addr == 32'h40) found = 1;
            end
            check("drain_reissue_0x40", 32'(found), 1);
        end
        push_exp(32'h40, 3);
        run_pops(3, 8'hFF);

        // Redirect coincident with ack and pop at count=1.
        apply_reset();
        mem_lat = 1;
        push_exp(32'h0, 5);
        run_pops(4, 8'hFF);
        step(1'b1, 1'b1, 32'h80);
        check("redir_pop_taken", 32'(popped), 1);
        check("redir_sb_empty", 32'(sb.size()), 0);
        step(1'b0, 1'b0, 32'h0);
        check("redir_flush_valid", instr_valid, 0);
        check("redir_flush_instr", instr, 0);
        check("redir_flush_pc", instr_pc, 0);
        check("redir_addr", imem_addr, 32'h80);
        check("redir_req", imem_req, 1);
        push_exp(32'h80, 2);
        run_pops(2, 8'hFF);

        // PC wrap from all-ones.
        apply_reset();
        mem_lat = 1;
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        repeat (5) step(1'b0, 1'b0, 32'h0);
        check("wrap_req_low", imem_req, 0);
        check("wrap_head_pc", instr_pc, 32'hFFFF_FFFF);
`ifdef IFU_PERF_CNT_EN
        check("perf_fetch_count", fetch_count, 2);
        check("perf_flush_count", 32'(flush_count), 1);
`endif
        push_exp(32'hFFFF_FFFF, 2);
        run_pops(2, 8'hFF);

        // Table of redirect targets, memory latencies and ready patterns.
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            mem_lat = vecs[i].lat;
            step(1'b0, 1'b1, vecs[i].rpc);
            sb.delete();
            for (int k = 0; k < vecs[i].n; k++) begin
                e.pc   = vecs[i].first_pc + 32'(k);
                e.data = (k == 0) ? vecs[i].first_instr : memf(e.pc);
                sb.push_back(e);
            end
            run_pops(vecs[i].n, vecs[i].rmask);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
